// File: rtl/weight_load_sched.sv
// Weight load scheduler: streams filter weights from a valid/ready port into
// per-filter buffers, one filter at a time, using a one-hot enable and a word address.
//
// state | meaning
// IDLE  | waiting for start; config is checked and latched here
// LOAD  | accepting beats for filter filt_idx
// NEXT  | one-cycle bubble while advancing to the next filter
// DONE  | one-cycle done pulse, counters cleared
module weight_load_sched #(
    parameter int NUM_BUF = 32,
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic                  abort_i,
    input  logic [5:0]            num_filter_i,
    input  logic [4:0]            weight_dim_i,
    input  logic                  s_valid_i,
    output logic                  s_ready_o,
    input  logic [2*DATA_W-1:0]   s_data_i,
    output logic [NUM_BUF-1:0]    weight_en_o,
    output logic [ADDR_W-1:0]     weight_addr_o,
    output logic [2*DATA_W-1:0]   weight_data_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  cfg_err_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        NEXT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [5:0]            filt_idx_q, filt_idx_d;
    logic [ADDR_W-1:0]     beat_cnt_q, beat_cnt_d;
    logic [5:0]            num_filter_q, num_filter_d;
    logic [4:0]            weight_dim_q, weight_dim_d;
    logic [NUM_BUF-1:0]    weight_en_q, weight_en_d;
    logic [ADDR_W-1:0]     weight_addr_q, weight_addr_d;
    logic [2*DATA_W-1:0]   weight_data_q, weight_data_d;
    logic                  cfg_err_q, cfg_err_d;

    logic cfg_bad;
    logic accept;
    logic last_beat;
    logic last_filt;

    assign cfg_bad   = (num_filter_i == 6'd0) || (num_filter_i > 6'(NUM_BUF)) ||
                       (weight_dim_i == 5'd0);
    assign accept    = s_valid_i && (state_q == LOAD);
    assign last_beat = (beat_cnt_q == ADDR_W'(weight_dim_q - 5'd1));
    assign last_filt = !(filt_idx_q < (num_filter_q - 6'd1));

    always_comb begin
        state_d       = state_q;
        filt_idx_d    = filt_idx_q;
        beat_cnt_d    = beat_cnt_q;
        num_filter_d  = num_filter_q;
        weight_dim_d  = weight_dim_q;
        weight_en_d   = '0;
        weight_addr_d = weight_addr_q;
        weight_data_d = weight_data_q;
        cfg_err_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    num_filter_d = num_filter_i;
                    weight_dim_d = weight_dim_i;
                    filt_idx_d   = '0;
                    beat_cnt_d   = '0;
                    if (cfg_bad) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                if (accept) begin
                    weight_en_d   = NUM_BUF'(1) << filt_idx_q;
                    weight_addr_d = beat_cnt_q;
                    weight_data_d = s_data_i;
                    beat_cnt_d    = beat_cnt_q + ADDR_W'(1);
                    if (last_beat) begin
                        state_d = last_filt ? DONE : NEXT;
                    end
                end
            end
            NEXT: begin
                filt_idx_d = filt_idx_q + 6'd1;
                beat_cnt_d = '0;
                state_d    = LOAD;
            end
            DONE: begin
                filt_idx_d = '0;
                beat_cnt_d = '0;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // The beat accepted alongside abort has already been steered above.
        if (abort_i && ((state_q == LOAD) || (state_q == NEXT))) begin
            state_d    = IDLE;
            filt_idx_d = '0;
            beat_cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            filt_idx_q    <= '0;
            beat_cnt_q    <= '0;
            num_filter_q  <= '0;
            weight_dim_q  <= '0;
            weight_en_q   <= '0;
            weight_addr_q <= '0;
            weight_data_q <= '0;
            cfg_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            filt_idx_q    <= filt_idx_d;
            beat_cnt_q    <= beat_cnt_d;
            num_filter_q  <= num_filter_d;
            weight_dim_q  <= weight_dim_d;
            weight_en_q   <= weight_en_d;
            weight_addr_q <= weight_addr_d;
            weight_data_q <= weight_data_d;
            cfg_err_q     <= cfg_err_d;
        end
    end

    assign s_ready_o     = (state_q == LOAD);
    assign busy_o        = (state_q == LOAD) || (state_q == NEXT);
    assign done_o        = (state_q == DONE);
    assign cfg_err_o     = cfg_err_q;
    assign weight_en_o   = weight_en_q;
    assign weight_addr_o = weight_addr_q;
    assign weight_data_o = weight_data_q;

endmodule

// File: tb/tb_weight_load_sched.sv
// Directed bench for weight_load_sched: hand-computed write sequences per scenario,
// checked with immediate assertions.
module tb_weight_load_sched;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic        abort_i;
    logic [5:0]  num_filter_i;
    logic [4:0]  weight_dim_i;
    logic        s_valid_i;
    logic        s_ready_o;
    logic [15:0] s_data_i;
    logic [31:0] weight_en_o;
    logic [4:0]  weight_addr_o;
    logic [15:0] weight_data_o;
    logic        busy_o;
    logic        done_o;
    logic        cfg_err_o;

    weight_load_sched dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .start_i       (start_i),
        .abort_i       (abort_i),
        .num_filter_i  (num_filter_i),
        .weight_dim_i  (weight_dim_i),
        .s_valid_i     (s_valid_i),
        .s_ready_o     (s_ready_o),
        .s_data_i      (s_data_i),
        .weight_en_o   (weight_en_o),
        .weight_addr_o (weight_addr_o),
        .weight_data_o (weight_data_o),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .cfg_err_o     (cfg_err_o)
    );

    always #5 clk_i = ~clk_i;

    int passed = 0;
    int total  = 0;

    // Write monitor, sampled on the falling edge.
    logic [31:0] wr_en[$];
    logic [4:0]  wr_addr[$];
    logic [15:0] wr_data[$];
    int          wr_cyc[$];
    int          cyc = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          cferr_cnt = 0;
    int          busy_cnt = 0;
    int          multihot = 0;

    always @(negedge clk_i) begin
        cyc++;
        if (weight_en_o != 32'd0) begin
            wr_en.push_back(weight_en_o);
            wr_addr.push_back(weight_addr_o);
            wr_data.push_back(weight_data_o);
            wr_cyc.push_back(cyc);
        end
        if ($countones(weight_en_o) > 1) multihot++;
        if (done_o) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (cfg_err_o) cferr_cnt++;
        if (busy_o) busy_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic clear_log();
        wr_en.delete();
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_start(input logic [5:0] nf, input logic [4:0] wd);
        num_filter_i = nf;
        weight_dim_i = wd;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    logic [15:0] base;
    int          beat;

    // Source side: s_data advances only after a handshake, so beat k carries base+k.
    task automatic stream(input int ncyc, input bit toggle, input int abort_at, input int start_at);
        logic hs;
        for (int c = 0; c < ncyc; c++) begin
            s_valid_i = toggle ? (c % 2 == 0) : 1'b1;
            abort_i   = (c == abort_at);
            start_i   = (c == start_at);
            if (c == start_at) begin
                num_filter_i = 6'd1;
                weight_dim_i = 5'd1;
            end
            #1;
            hs = s_valid_i && s_ready_o;
            @(posedge clk_i);
            #1;
            if (hs) begin
                beat++;
                s_data_i = base + 16'(beat);
            end
        end
        s_valid_i = 1'b0;
        abort_i   = 1'b0;
        start_i   = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_s_ready"}, s_ready_o, 0);
        chk({tag, "_en"}, weight_en_o, 0);
        chk({tag, "_addr"}, weight_addr_o, 0);
        chk({tag, "_data"}, weight_data_o, 0);
        chk({tag, "_busy"}, busy_o, 0);
        chk({tag, "_done"}, done_o, 0);
        chk({tag, "_cfg_err"}, cfg_err_o, 0);
    endtask

    int d0, b0, c0;

    initial begin
        rst_i = 1'b1;
        start_i = 1'b0;
        abort_i = 1'b0;
        num_filter_i = '0;
        weight_dim_i = '0;
        s_valid_i = 1'b0;
        s_data_i = '0;
        tick();
        tick();
        check_outputs_zero("reset");
        rst_i = 1'b0;
        tick();
        check_outputs_zero("post_reset");

        // T1: 2 filters x 3 beats, continuous valid, config inputs change after start
        clear_log();
        d0 = done_cnt;
        base = 16'h1000; beat = 0; s_data_i = base;
        do_start(6'd2, 5'd3);
        num_filter_i = 6'd5;
        weight_dim_i = 5'd7;
        stream(12, 1'b0, -1, -1);
        chk("t1_nwrites", wr_en.size(), 6);
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("t1_en%0d", k), wr_en[k], (k < 3) ? 32'h1 : 32'h2);
            chk($sformatf("t1_addr%0d", k), wr_addr[k], k % 3);
            chk($sformatf("t1_data%0d", k), wr_data[k], 16'h1000 + 16'(k));
        end
        chk("t1_back2back", wr_cyc[1] - wr_cyc[0], 1);
        chk("t1_gap", wr_cyc[3] - wr_cyc[2], 2);
        chk("t1_done", done_cnt - d0, 1);
        chk("t1_done_after_writes", done_cyc >= wr_cyc[5], 1);
        chk("t1_idle", busy_o, 0);

        // T2: same config, valid toggling
        clear_log();
        d0 = done_cnt;
        base = 16'h2000; beat = 0; s_data_i = base;
        do_start(6'd2, 5'd3);
        stream(24, 1'b1, -1, -1);
        chk("t2_nwrites", wr_en.size(), 6);
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("t2_en%0d", k), wr_en[k], (k < 3) ? 32'h1 : 32'h2);
            chk($sformatf("t2_addr%0d", k), wr_addr[k], k % 3);
            chk($sformatf("t2_data%0d", k), wr_data[k], 16'h2000 + 16'(k));
        end
        chk("t2_stall_gap", wr_cyc[1] - wr_cyc[0], 2);
        chk("t2_done", done_cnt - d0, 1);

        // T3: 32 filters x 1 beat, enable walks across all buffers
        clear_log();
        d0 = done_cnt;
        base = 16'h3000; beat = 0; s_data_i = base;
        do_start(6'd32, 5'd1);
        stream(72, 1'b0, -1, -1);
        chk("t3_nwrites", wr_en.size(), 32);
        for (int k = 0; k < 32; k++) begin
            logic [31:0] e;
            e = 32'd1 << k;
            chk($sformatf("t3_en%0d", k), wr_en[k], e);
            chk($sformatf("t3_addr%0d", k), wr_addr[k], 0);
        end
        chk("t3_data_last", wr_data[31], 16'h301f);
        chk("t3_done", done_cnt - d0, 1);

        // T4: illegal configs
        clear_log();
        c0 = cferr_cnt;
        b0 = busy_cnt;
        s_valid_i = 1'b1;
        do_start(6'd0, 5'd4);
        chk("t4_nf0_err", cfg_err_o, 1);
        tick();
        chk("t4_nf0_pulse", cfg_err_o, 0);
        do_start(6'd33, 5'd4);
        chk("t4_nf33_err", cfg_err_o, 1);
        tick();
        chk("t4_nf33_pulse", cfg_err_o, 0);
        do_start(6'd4, 5'd0);
        chk("t4_wd0_err", cfg_err_o, 1);
        tick();
        tick();
        s_valid_i = 1'b0;
        chk("t4_err_count", cferr_cnt - c0, 3);
        chk("t4_busy", busy_cnt - b0, 0);
        chk("t4_nwrites", wr_en.size(), 0);
        chk("t4_ready", s_ready_o, 0);

        // T5: abort on 2nd beat of filter 1, then a fresh load
        clear_log();
        d0 = done_cnt;
        b0 = busy_cnt;
        base = 16'h5000; beat = 0; s_data_i = base;
        do_start(6'd4, 5'd4);
        stream(12, 1'b0, 6, -1);
        chk("t5_nwrites", wr_en.size(), 6);
        chk("t5_last_en", wr_en[5], 32'h2);
        chk("t5_last_addr", wr_addr[5], 1);
        chk("t5_last_data", wr_data[5], 16'h5005);
        chk("t5_busy_cycles", busy_cnt - b0, 7);
        chk("t5_no_done", done_cnt - d0, 0);
        chk("t5_ready", s_ready_o, 0);
        clear_log();
        base = 16'h5100; beat = 0; s_data_i = base;
        do_start(6'd1, 5'd2);
        stream(6, 1'b0, -1, -1);
        chk("t5_re_nwrites", wr_en.size(), 2);
        chk("t5_re_en", wr_en[0], 32'h1);
        chk("t5_re_addr0", wr_addr[0], 0);
        chk("t5_re_addr1", wr_addr[1], 1);
        chk("t5_re_done", done_cnt - d0, 1);

        // T6: start while busy is ignored; reset mid-load
        clear_log();
        d0 = done_cnt;
        c0 = cferr_cnt;
        base = 16'h6000; beat = 0; s_data_i = base;
        do_start(6'd2, 5'd3);
        stream(4, 1'b0, -1, 2);
        chk("t6_nwrites", wr_en.size(), 3);
        chk("t6_last_en", wr_en[2], 32'h1);
        chk("t6_last_addr", wr_addr[2], 2);
        chk("t6_busy_next", busy_o, 1);
        rst_i = 1'b1;
        s_valid_i = 1'b1;
        tick();
        check_outputs_zero("t6_rst");
        rst_i = 1'b0;
        s_valid_i = 1'b0;
        tick();
        chk("t6_nwrites_after_rst", wr_en.size(), 3);
        chk("t6_no_done", done_cnt - d0, 0);
        chk("t6_no_cfg_err", cferr_cnt - c0, 0);
        clear_log();
        base = 16'h6100; beat = 0; s_data_i = base;
        do_start(6'd1, 5'd1);
        stream(4, 1'b0, -1, -1);
        chk("t6_re_nwrites", wr_en.size(), 1);
        chk("t6_re_en", wr_en[0], 32'h1);
        chk("t6_re_addr", wr_addr[0], 0);
        chk("t6_re_data", wr_data[0], 16'h6100);

        chk("never_multihot", multihot, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
